// File: rtl/led_display_row_shifter.sv
// Serial row shifter for a HUB75-style LED panel: clocks one pixel pair per bit_clk
// pulse, then blanks, latches and unblanks the completed row pair.
module led_display_row_shifter #(
    parameter int NUM_ROWS     = 32,
    parameter int NUM_COLS     = 64,
    parameter int WRITE_FREQ   = 1_000_000,
    parameter int SYS_CLK_FREQ = 100_000_000,
    localparam int ADDR_W      = ((NUM_ROWS / 2) > 1) ? $clog2(NUM_ROWS / 2) : 1
) (
    input  logic              clk_in,
    input  logic              n_reset_in,
    input  logic              pixel_valid_in,
    output logic              pixel_ready_out,
    input  logic [23:0]       pixel_top_in,
    input  logic [23:0]       pixel_bot_in,
    output logic [2:0]        rgb_top_out,
    output logic [2:0]        rgb_bot_out,
    output logic              bit_clk_out,
    output logic              latch_enable_out,
    output logic              output_enable_out,
    output logic [ADDR_W-1:0] addr_out,
    output logic              row_done_out
);

    localparam int HALF_RAW = SYS_CLK_FREQ / (2 * WRITE_FREQ);
    localparam int HALF_PER = (HALF_RAW < 1) ? 1 : HALF_RAW;
    localparam int CNT_W    = $clog2(HALF_PER + 1);
    localparam int COL_W    = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;

    localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(HALF_PER - 1);
    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(NUM_COLS - 1);
    localparam logic [ADDR_W-1:0] ROW_LAST  = ADDR_W'(NUM_ROWS / 2 - 1);

    typedef enum logic [2:0] {IDLE, SETUP, HIGH, BLANK, LATCH} state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_half_cnt;
    logic [COL_W-1:0]   r_col_count;
    logic [ADDR_W-1:0]  r_row_ptr;
    logic               r_ready;
    logic [2:0]         r_rgb_top;
    logic [2:0]         r_rgb_bot;
    logic               r_bit_clk;
    logic               r_latch_en;
    logic               r_out_en;
    logic [ADDR_W-1:0]  r_addr;
    logic               r_row_done;

    logic w_half_done;
    logic w_xfer;

    assign w_half_done = (r_half_cnt == HALF_LAST);
    assign w_xfer      = pixel_valid_in && r_ready && (r_state == IDLE);

    // Ready is registered so it stays low during reset and rises on the first edge after.
    always_ff @(posedge clk_in or negedge n_reset_in) begin
        if (!n_reset_in) begin
            r_state     <= IDLE;
            r_half_cnt  <= '0;
            r_col_count <= '0;
            r_row_ptr   <= '0;
            r_ready     <= 1'b0;
            r_rgb_top   <= '0;
            r_rgb_bot   <= '0;
            r_bit_clk   <= 1'b0;
            r_latch_en  <= 1'b0;
            r_out_en    <= 1'b1;
            r_addr      <= '0;
            r_row_done  <= 1'b0;
        end else begin
            r_row_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_xfer) begin
                        r_rgb_top  <= {pixel_top_in[23], pixel_top_in[15], pixel_top_in[7]};
                        r_rgb_bot  <= {pixel_bot_in[23], pixel_bot_in[15], pixel_bot_in[7]};
                        r_ready    <= 1'b0;
                        r_half_cnt <= '0;
                        r_state    <= SETUP;
                    end else begin
                        r_ready <= 1'b1;
                    end
                end
                SETUP: begin
                    if (w_half_done) begin
                        r_bit_clk  <= 1'b1;
                        r_half_cnt <= '0;
                        r_state    <= HIGH;
                    end else begin
                        r_half_cnt <= r_half_cnt + CNT_W'(1);
                    end
                end
                HIGH: begin
                    if (w_half_done) begin
                        r_bit_clk  <= 1'b0;
                        r_half_cnt <= '0;
                        if (r_col_count == COL_LAST) begin
                            r_col_count <= '0;
                            r_out_en    <= 1'b1;
                            r_state     <= BLANK;
                        end else begin
                            r_col_count <= r_col_count + COL_W'(1);
                            r_ready     <= 1'b1;
                            r_state     <= IDLE;
                        end
                    end else begin
                        r_half_cnt <= r_half_cnt + CNT_W'(1);
                    end
                end
                BLANK: begin
                    // Address only moves while the panel is blanked.
                    if (w_half_done) begin
                        r_latch_en <= 1'b1;
                        r_addr     <= r_row_ptr;
                        r_half_cnt <= '0;
                        r_state    <= LATCH;
                    end else begin
                        r_half_cnt <= r_half_cnt + CNT_W'(1);
                    end
                end
                LATCH: begin
                    if (w_half_done) begin
                        r_latch_en <= 1'b0;
                        r_out_en   <= 1'b0;
                        r_row_done <= 1'b1;
                        r_row_ptr  <= (r_row_ptr == ROW_LAST) ? '0 : r_row_ptr + ADDR_W'(1);
                        r_ready    <= 1'b1;
                        r_half_cnt <= '0;
                        r_state    <= IDLE;
                    end else begin
                        r_half_cnt <= r_half_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_half_cnt <= '0;
                    r_ready    <= 1'b0;
                    r_state    <= IDLE;
                end
            endcase
        end
    end

    assign pixel_ready_out   = r_ready;
    assign rgb_top_out       = r_rgb_top;
    assign rgb_bot_out       = r_rgb_bot;
    assign bit_clk_out       = r_bit_clk;
    assign latch_enable_out  = r_latch_en;
    assign output_enable_out = r_out_en;
    assign addr_out          = r_addr;
    assign row_done_out      = r_row_done;

endmodule

// File: tb/tb_led_display_row_shifter.sv
// Bench for led_display_row_shifter: directed and random pixel streams checked
// against a transaction-level timing model of the row shifter.
module tb_led_display_row_shifter;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;
    localparam int SYS_F    = 4;
    localparam int WR_F     = 1;
    localparam int HP       = (SYS_F / (2 * WR_F) < 1) ? 1 : SYS_F / (2 * WR_F);
    localparam int NPAIRS   = NUM_ROWS / 2;
    localparam int AW       = (NPAIRS > 1) ? $clog2(NPAIRS) : 1;

    logic          clk = 1'b0;
    logic          n_reset_in;
    logic          pixel_valid_in;
    logic          pixel_ready_out;
    logic [23:0]   pixel_top_in;
    logic [23:0]   pixel_bot_in;
    logic [2:0]    rgb_top_out;
    logic [2:0]    rgb_bot_out;
    logic          bit_clk_out;
    logic          latch_enable_out;
    logic          output_enable_out;
    logic [AW-1:0] addr_out;
    logic          row_done_out;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state: what the panel should show, tracked per transaction.
    int       m_col = 0;
    int       m_row = 0;
    int       m_addr = 0;
    bit       m_oe = 1'b1;
    logic [2:0] m_rgb_top = 3'b000;
    logic [2:0] m_rgb_bot = 3'b000;

    led_display_row_shifter #(
        .NUM_ROWS(NUM_ROWS),
        .NUM_COLS(NUM_COLS),
        .WRITE_FREQ(WR_F),
        .SYS_CLK_FREQ(SYS_F)
    ) dut (
        .clk_in(clk),
        .n_reset_in(n_reset_in),
        .pixel_valid_in(pixel_valid_in),
        .pixel_ready_out(pixel_ready_out),
        .pixel_top_in(pixel_top_in),
        .pixel_bot_in(pixel_bot_in),
        .rgb_top_out(rgb_top_out),
        .rgb_bot_out(rgb_bot_out),
        .bit_clk_out(bit_clk_out),
        .latch_enable_out(latch_enable_out),
        .output_enable_out(output_enable_out),
        .addr_out(addr_out),
        .row_done_out(row_done_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic check_outs(input bit bclk, input bit rdy, input bit le, input bit oe, input bit rd);
        chk("bit_clk", 32'(bit_clk_out), 32'(bclk));
        chk("ready", 32'(pixel_ready_out), 32'(rdy));
        chk("latch_en", 32'(latch_enable_out), 32'(le));
        chk("out_en", 32'(output_enable_out), 32'(oe));
        chk("row_done", 32'(row_done_out), 32'(rd));
        chk("addr", 32'(addr_out), 32'(m_addr));
        chk("rgb_top", 32'(rgb_top_out), 32'(m_rgb_top));
        chk("rgb_bot", 32'(rgb_bot_out), 32'(m_rgb_bot));
    endtask

    task automatic model_reset();
        m_col = 0;
        m_row = 0;
        m_addr = 0;
        m_oe = 1'b1;
        m_rgb_top = 3'b000;
        m_rgb_bot = 3'b000;
    endtask

    task automatic idle(input int n);
        pixel_valid_in = 1'b0;
        repeat (n) begin
            @(negedge clk);
            check_outs(1'b0, 1'b1, 1'b0, m_oe, 1'b0);
        end
    endtask

    // Offer one pixel pair (called on a negedge) and follow it through its bit
    // clock pulse and, for the last column, the blank/latch/unblank sequence.
    task automatic send(input logic [23:0] t, input logic [23:0] b, input bit hold);
        int  n;
        int  jmax;
        bit  last;
        bit  e_bclk, e_rdy, e_le, e_oe, e_rd;
        pixel_top_in = t;
        pixel_bot_in = b;
        pixel_valid_in = 1'b1;
        n = 0;
        while (pixel_ready_out !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", 32'(n < 40), 32'd1);
        last = (m_col == NUM_COLS - 1);
        m_rgb_top = {t[23], t[15], t[7]};
        m_rgb_bot = {b[23], b[15], b[7]};
        jmax = last ? 4 * HP : 2 * HP;
        for (int j = 0; j <= jmax; j++) begin
            @(negedge clk);
            if (last && j == 3 * HP) m_addr = m_row;
            e_bclk = (j >= HP) && (j < 2 * HP);
            e_rdy  = (j == jmax);
            e_le   = last && (j >= 3 * HP) && (j < 4 * HP);
            e_rd   = last && (j == 4 * HP);
            if (last && j >= 2 * HP) e_oe = (j < 4 * HP);
            else                     e_oe = m_oe;
            check_outs(e_bclk, e_rdy, e_le, e_oe, e_rd);
            if (!hold && j == 0) pixel_valid_in = 1'b0;
            if (hold && last && j >= 2 * HP && j < 4 * HP) begin
                pixel_top_in = 24'($urandom());
                pixel_bot_in = 24'($urandom());
            end
        end
        if (last) begin
            m_col = 0;
            m_row = (m_row + 1) % NPAIRS;
            m_oe = 1'b0;
        end else begin
            m_col++;
        end
    endtask

    initial begin
        n_reset_in = 1'b0;
        pixel_valid_in = 1'b0;
        pixel_top_in = 24'h0;
        pixel_bot_in = 24'h0;
        model_reset();

        // Held in reset: everything static, panel blanked, not ready.
        repeat (2) @(negedge clk);
        check_outs(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        n_reset_in = 1'b1;
        idle(20);

        // Known pixel, then the rest of row 0 with gaps.
        send(24'h800080, 24'h008000, 1'b0);
        chk("rgb_top_known", 32'(rgb_top_out), 32'h5);
        chk("rgb_bot_known", 32'(rgb_bot_out), 32'h2);
        for (int c = 1; c < NUM_COLS; c++) send(24'($urandom()), 24'($urandom()), 1'b0);
        idle(3);

        // Rows 1 and 2 back-to-back with valid held; row 2 wraps the address.
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < NUM_COLS; c++) send(24'($urandom()), 24'($urandom()), 1'b1);
        idle(2);

        // Long valid gap mid-row must not disturb the column count.
        send(24'($urandom()), 24'($urandom()), 1'b0);
        send(24'($urandom()), 24'($urandom()), 1'b0);
        idle(7);
        send(24'($urandom()), 24'($urandom()), 1'b0);
        send(24'($urandom()), 24'($urandom()), 1'b0);
        idle(2);

        // Reset after two pixels aborts the row; the next full row latches row 0.
        send(24'($urandom()), 24'($urandom()), 1'b0);
        send(24'($urandom()), 24'($urandom()), 1'b0);
        n_reset_in = 1'b0;
        model_reset();
        #1;
        check_outs(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        n_reset_in = 1'b1;
        idle(1);
        for (int c = 0; c < NUM_COLS; c++) send(24'($urandom()), 24'($urandom()), 1'b0);
        idle(2);

        // Random rows with random hold behaviour and idle gaps.
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < NUM_COLS; c++) begin
                send(24'($urandom()), 24'($urandom()), 1'($urandom_range(0, 1)));
                if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 5)));
            end
        end
        idle(4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/led_display_row_shifter.md
LED_DISPLAY_ROW_SHIFTER -- requirements
Module: led_display_row_shifter

Interface
REQ-001 Parameter NUM_ROWS, default 32: panel rows; NUM_ROWS/2 row pairs; ADDR_W = $clog2(NUM_ROWS/2), minimum 1.
REQ-002 Parameter NUM_COLS, default 64: pixels shifted per row pair.
REQ-003 Parameter WRITE_FREQ, default 1_000_000: bit clock frequency in Hz.
REQ-004 Parameter SYS_CLK_FREQ, default 100_000_000: clk_in frequency in Hz; HALF_PER = max(1, SYS_CLK_FREQ/(2*WRITE_FREQ)) cycles, integer division.
REQ-005 clk_in  input  1  system clock; the block has one clock, all logic on its rising edge.
REQ-006 n_reset_in  input  1  reset, asynchronous assert, active-low.
REQ-007 pixel_valid_in  input  1  upstream offers a pixel pair.
REQ-008 pixel_ready_out  output  1  block accepts a pixel pair this cycle.
REQ-009 pixel_top_in  input  24  top-half pixel, {R[7:0],G[7:0],B[7:0]}.
REQ-010 pixel_bot_in  input  24  bottom-half pixel, same format.
REQ-011 rgb_top_out  output  3  {R,G,B} serial data, top half.
REQ-012 rgb_bot_out  output  3  {R,G,B} serial data, bottom half.
REQ-013 bit_clk_out  output  1  panel shift clock; panel samples on rising edge.
REQ-014 latch_enable_out  output  1  1 = transfer shift register to row latch.
REQ-015 output_enable_out  output  1  panel OE polarity: 1 = display blanked, 0 = lit.
REQ-016 addr_out  output  ADDR_W  row-pair address currently displayed.
REQ-017 row_done_out  output  1  one-cycle pulse when a row pair has been latched and unblanked.

Function
REQ-018 The FSM SHALL have states IDLE, SETUP, HIGH, BLANK, LATCH.
REQ-019 pixel_ready_out SHALL be 1 only in IDLE; a transfer occurs on a rising edge with pixel_valid_in=1 and pixel_ready_out=1.
REQ-020 On transfer: rgb_top_out <= {top[23],top[15],top[7]}, rgb_bot_out <= {bot[23],bot[15],bot[7]} (channel MSBs); state -> SETUP; bit_clk_out stays 0.
REQ-021 Input pixels SHALL be ignored outside IDLE; rgb outputs SHALL hold from transfer until the next transfer.
REQ-022 SETUP SHALL last HALF_PER cycles, then bit_clk_out <= 1, state -> HIGH.
REQ-023 HIGH SHALL last HALF_PER cycles, then bit_clk_out <= 0 and col_count increments; if col_count was NUM_COLS-1 then col_count <= 0 and state -> BLANK, else state -> IDLE.
REQ-024 Transfer at edge k: bit_clk_out rises at edge k+HALF_PER, falls at k+2*HALF_PER; next transfer possible at k+2*HALF_PER+1 at the earliest.
REQ-025 Entering BLANK: output_enable_out <= 1; BLANK lasts HALF_PER cycles.
REQ-026 BLANK->LATCH edge: latch_enable_out <= 1, addr_out <= row_ptr; LATCH lasts HALF_PER cycles.
REQ-027 LATCH->IDLE edge: latch_enable_out <= 0, output_enable_out <= 0, row_done_out <= 1 for exactly one cycle, row_ptr <= row_ptr+1 wrapping NUM_ROWS/2-1 -> 0.
REQ-028 pixel_ready_out SHALL be 0 throughout BLANK and LATCH; bit_clk_out SHALL be 0 throughout.
REQ-029 addr_out SHALL change only on BLANK->LATCH edges, i.e. only while output_enable_out=1.
REQ-030 pixel_valid_in deasserting between pixels SHALL stall in IDLE indefinitely with all outputs held; no timeout.
REQ-031 Half-period counter width SHALL be $clog2(HALF_PER+1); counter resets to 0 on every state change.

Reset
REQ-032 While n_reset_in=0: state IDLE, rgb_top_out=0, rgb_bot_out=0, bit_clk_out=0, latch_enable_out=0, output_enable_out=1, addr_out=0, row_done_out=0, col_count=0, row_ptr=0, half counter=0.
REQ-033 pixel_ready_out SHALL be 0 while n_reset_in=0 and SHALL be 1 on the first rising edge after deassertion.
REQ-034 Reset asserted mid-row or mid-latch SHALL abort immediately; a partially shifted row is discarded, and the panel stays blanked until a full row completes.

Verification (NUM_COLS=4, NUM_ROWS=4, SYS_CLK_FREQ=4, WRITE_FREQ=1 -> HALF_PER=2, ADDR_W=1)
REQ-035 Reset release, valid=0 -> ready=1, OE=1, bit_clk=0, addr=0, all outputs static for 20 cycles.
REQ-036 Single transfer top=24'h800080, bot=24'h008000 at edge k -> rgb_top=3'b101, rgb_bot=3'b010 from k; bit_clk=1 on edges k+2..k+3; ready=1 at k+4.
REQ-037 4 back-to-back transfers, valid held high -> 4 bit_clk pulses 5 cycles apart; OE=1 from the 4th falling edge, LE=1 for 2 cycles with addr=0, then OE=0, row_done pulse; second row -> addr=1; third row -> addr wraps to 0.
REQ-038 valid held high during BLANK/LATCH with changing pixel data -> ready=0, no bit_clk edges, rgb outputs unchanged, data not consumed.
REQ-039 Reset asserted after 2 of 4 pixels, released, then 4 pixels -> no latch after pixels 3-4 of the aborted row; latch occurs only after the 4th post-reset pixel, addr=0.
REQ-040 valid gap of 7 cycles between pixels 2 and 3 -> bit_clk pulse count still 4 per row; no early latch.
